// File: rtl/td4_pkg.sv
// Shared TD4 widths and the program-loader FSM state encoding.
// The CHK state is only present when PROG_LOADER_CHECKSUM_EN is defined.
package td4_pkg;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int PROG_DEPTH = 16;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CHK = 2'd2} ld_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} ld_state_t;
`endif
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake between an external program source and prog_loader.
interface prog_loader_if;
  import td4_pkg::*;

  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (output ld_start, ld_valid, ld_data, input ld_ready);
  modport slave  (input ld_start, ld_valid, ld_data, output ld_ready);
endinterface

// File: rtl/prog_mem.sv
// 16 x 8 program store: synchronous write, asynchronous read, synchronous clear.
module prog_mem
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_reg [PROG_DEPTH];

  // Register-based so the whole array can be wiped in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];
endmodule

// File: rtl/prog_loader.sv
// Loads 16 instruction bytes into program memory while holding the CPU in reset.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      ld,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  ld_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic              done_reg, done_next;
  logic              ready;
  logic              we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      wptr_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    done_next  = 1'b0;
    ready      = 1'b0;
    cpu_hold   = 1'b0;
    we         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ld.ld_start) begin
          state_next = ST_LOAD;
          wptr_next  = '0;
        end
      end
      ST_LOAD: begin
        ready    = 1'b1;
        cpu_hold = 1'b1;
        if (ld.ld_valid) begin
          we        = 1'b1;
          wptr_next = wptr_reg + ADDR_W'(1);
          if (wptr_reg == ADDR_W'(PROG_DEPTH - 1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_next = ST_CHK;
`else
            state_next = ST_IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        ready    = 1'b1;
        cpu_hold = 1'b1;
        if (ld.ld_valid) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign ld.ld_ready = ready;
  // done is registered, so it lands in the first IDLE cycle after the load.
  assign done        = done_reg;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
  logic [DATA_W-1:0] chk_total;
  logic              err_reg;

  assign chk_total = sum_reg + ld.ld_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
      err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && ld.ld_start) begin
      sum_reg <= '0;
      err_reg <= 1'b0;
    end else if (we) begin
      sum_reg <= chk_total;
    end else if (state_reg == ST_CHK && ld.ld_valid) begin
      err_reg <= (chk_total != '0);
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  prog_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wptr_reg),
    .wdata (ld.ld_data),
    .raddr (address),
    .rdata (data)
  );
endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (both PROG_LOADER_CHECKSUM_EN builds).
module tb_prog_loader;
  import td4_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] address;
  logic [7:0] data;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_mem [16];
  logic [7:0] tbl_a [16] = '{8'hB7, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hFF};
  logic [7:0] tbl_b [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
  logic [7:0] tbl_c [16] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57,
                             8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F};

  prog_loader_if lif ();

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (lif),
    .address  (address),
    .data     (data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Inputs must be quiet while this runs; it spans more than one clock.
  task automatic readback(input string tag);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), data, exp_mem[i]);
    end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    address       = 4'h0;
    lif.ld_start  = 1'b0;
    lif.ld_valid  = 1'b0;
    lif.ld_data   = 8'h00;
    tick();
    tick();
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_ready", lif.ld_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    readback("rst_mem");

    // Back-to-back load.
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    chk("ld_hold", cpu_hold, 1'b1);
    chk("ld_ready", lif.ld_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      lif.ld_valid = 1'b1;
      lif.ld_data  = tbl_a[i];
      address      = 4'(i);
      tick();
      chk($sformatf("wr_vis[%0d]", i), data, tbl_a[i]);
      if (i < 15) chk("done_early", done, 1'b0);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("chk_hold", cpu_hold, 1'b1);
    chk("chk_ready", lif.ld_ready, 1'b1);
    chk("chk_nodone", done, 1'b0);
    lif.ld_data = 8'hE1;
    tick();
    chk("a_err", err, 1'b0);
`endif
    lif.ld_valid = 1'b0;
    chk("a_done", done, 1'b1);
    chk("a_hold_off", cpu_hold, 1'b0);
    tick();
    chk("a_done_once", done, 1'b0);
    chk("a_ready_idle", lif.ld_ready, 1'b0);
    address = 4'h0; #1;
    chk("a_mem0", data, 8'hB7);
    address = 4'hF; #1;
    chk("a_memF", data, 8'hFF);
    tick();
    $display("load A: 16 bytes, first %h last %h", 8'hB7, 8'hFF);

    // Valid toggling every cycle; hold must stay high the whole time.
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("tog_hold[%0d]", c), cpu_hold, 1'b1);
      lif.ld_valid = c[0];
      lif.ld_data  = c[0] ? tbl_b[c/2] : 8'hEE;
      tick();
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    lif.ld_valid = 1'b1;
    lif.ld_data  = 8'h88;
    tick();
    chk("b_err", err, 1'b0);
`endif
    lif.ld_valid = 1'b0;
    chk("b_done", done, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) exp_mem[i] = tbl_b[i];
    readback("b_mem");
    $display("load B: 16 bytes with stalls");

    // Reset after five bytes, with start/valid also asserted in the reset cycle.
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lif.ld_valid = 1'b1;
      lif.ld_data  = 8'hC0 + 8'(i);
      tick();
    end
    reset        = 1'b1;
    lif.ld_start = 1'b1;
    lif.ld_data  = 8'h99;
    tick();
    reset        = 1'b0;
    lif.ld_start = 1'b0;
    lif.ld_valid = 1'b0;
    chk("abort_hold", cpu_hold, 1'b0);
    chk("abort_ready", lif.ld_ready, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_done2", done, 1'b0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    readback("abort_mem");
    $display("load C: aborted by reset after 5 bytes");

    // ld_valid in IDLE must not write.
    address      = 4'h0;
    lif.ld_valid = 1'b1;
    lif.ld_data  = 8'hAA;
    #1;
    chk("idle_ready", lif.ld_ready, 1'b0);
    tick();
    tick();
    lif.ld_valid = 1'b0;
    chk("idle_nowrite", data, 8'h00);
    chk("idle_hold", cpu_hold, 1'b0);
    tick();

    // ld_start mid-load (and during CHK) must be ignored.
    lif.ld_start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      lif.ld_start = (i == 8);
      lif.ld_valid = 1'b1;
      lif.ld_data  = tbl_c[i];
      tick();
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    lif.ld_start = 1'b1;
    lif.ld_data  = 8'h88;
    tick();
    chk("d_err", err, 1'b0);
`endif
    lif.ld_start = 1'b0;
    lif.ld_valid = 1'b0;
    chk("d_done", done, 1'b1);
    chk("d_err_off", err, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) exp_mem[i] = tbl_c[i];
    readback("d_mem");
    $display("load D: ld_start mid-load ignored");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum: 16 x 01 sums to 0x10, plus F0 wraps to 0.
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    lif.ld_valid = 1'b1;
    lif.ld_data  = 8'h01;
    for (int i = 0; i < 16; i++) tick();
    lif.ld_data  = 8'hF0;
    tick();
    lif.ld_valid = 1'b0;
    chk("e_done", done, 1'b1);
    chk("e_err", err, 1'b0);
    tick();
    $display("load E: checksum F0 accepted");

    // Bad checksum: 0x10 + F1 = 0x01.
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    lif.ld_valid = 1'b1;
    lif.ld_data  = 8'h01;
    for (int i = 0; i < 16; i++) tick();
    lif.ld_data  = 8'hF1;
    tick();
    lif.ld_valid = 1'b0;
    chk("f_done", done, 1'b1);
    chk("f_err", err, 1'b1);
    tick();
    chk("f_err_hold", err, 1'b1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h01;
    readback("f_mem");
    chk("f_err_hold2", err, 1'b1);
    lif.ld_start = 1'b1;
    tick();
    lif.ld_start = 1'b0;
    chk("f_err_clr", err, 1'b0);
    $display("load F: checksum F1 flagged, cleared by next start");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
